// File: rtl/timer_ctrl_pkg.sv
// Shared encodings for the countdown timer controller: BCD digit constants,
// controller state encoding and field-select codes.
package timer_ctrl_pkg;

  localparam int BCD_BIT_WIDTH = 4;

  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_FIVE = 4'd5;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

  typedef enum logic [2:0] {
    TC_IDLE  = 3'd0,
    TC_SET_H = 3'd1,
    TC_SET_M = 3'd2,
    TC_RUN   = 3'd3,
    TC_PAUSE = 3'd4,
    TC_ALARM = 3'd5
  } tc_state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

endpackage

// File: rtl/timer_ctrl_bcd2_inc.sv
// Combinational two-digit BCD incrementer; wraps to 00 in one step when the
// pair equals the supplied limit.
module bcd2_inc
  import timer_ctrl_pkg::*;
(
  input  logic [BCD_BIT_WIDTH-1:0] tens,
  input  logic [BCD_BIT_WIDTH-1:0] ones,
  input  logic [BCD_BIT_WIDTH-1:0] limit_tens,
  input  logic [BCD_BIT_WIDTH-1:0] limit_ones,
  output logic [BCD_BIT_WIDTH-1:0] tens_nx,
  output logic [BCD_BIT_WIDTH-1:0] ones_nx
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tens_nx = tens;
    ones_nx = ones + 4'd1;
    if (tens == limit_tens && ones == limit_ones) begin
      tens_nx = BCD_ZERO;
      ones_nx = BCD_ZERO;
    end else if (ones == BCD_NINE) begin
      tens_nx = tens + 4'd1;
      ones_nx = BCD_ZERO;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the HH:MM:SS BCD countdown: preset entry, load,
// run gating, pause/resume and a tick-timed alarm.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int HOUR_MAX    = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_1hz,
  input  logic                     btn_mode,
  input  logic                     btn_inc,
  input  logic                     btn_start,
  input  logic                     cnt_zero,
  output logic [BCD_BIT_WIDTH-1:0] init_value_h1,
  output logic [BCD_BIT_WIDTH-1:0] init_value_h0,
  output logic [BCD_BIT_WIDTH-1:0] init_value_m1,
  output logic [BCD_BIT_WIDTH-1:0] init_value_m0,
  output logic                     load,
  output logic [1:0]               en_start,
  output logic [1:0]               field_sel,
  output logic                     alarm
);

  localparam int CNT_W = $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS - 1);
  localparam logic [BCD_BIT_WIDTH-1:0] HOUR_LIM_T = BCD_BIT_WIDTH'(HOUR_MAX / 10);
  localparam logic [BCD_BIT_WIDTH-1:0] HOUR_LIM_O = BCD_BIT_WIDTH'(HOUR_MAX % 10);

  tc_state_e                state_q, state_d;
  logic [BCD_BIT_WIDTH-1:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [CNT_W-1:0]         alarm_cnt_q, alarm_cnt_d;
  logic                     load_q, load_d;
  logic                     guard_q, guard_d;
  logic [1:0]               en_start_q, en_start_d;
  logic [1:0]               field_sel_q, field_sel_d;
  logic                     alarm_q, alarm_d;

  logic [BCD_BIT_WIDTH-1:0] h1_nx, h0_nx, m1_nx, m0_nx;
  logic                     preset_nz;
  logic                     any_btn;

  bcd2_inc u_hour_inc (
    .tens       (h1_q),
    .ones       (h0_q),
    .limit_tens (HOUR_LIM_T),
    .limit_ones (HOUR_LIM_O),
    .tens_nx    (h1_nx),
    .ones_nx    (h0_nx)
  );

  bcd2_inc u_min_inc (
    .tens       (m1_q),
    .ones       (m0_q),
    .limit_tens (BCD_FIVE),
    .limit_ones (BCD_NINE),
    .tens_nx    (m1_nx),
    .ones_nx    (m0_nx)
  );

  assign preset_nz = |{h1_q, h0_q, m1_q, m0_q};
  assign any_btn   = btn_start | btn_mode | btn_inc;

  always_comb begin
    state_d     = state_q;
    h1_d        = h1_q;
    h0_d        = h0_q;
    m1_d        = m1_q;
    m0_d        = m0_q;
    alarm_cnt_d = alarm_cnt_q;
    load_d      = 1'b0;
    // The datapath copies presets at the end of the load cycle, so cnt_zero is
    // untrustworthy during that cycle and the one after it.
    guard_d     = load_q;

    unique case (state_q)
      TC_IDLE: begin
        if (btn_start) begin
          if (preset_nz) begin
            load_d  = 1'b1;
            state_d = TC_RUN;
          end
        end else if (btn_mode) begin
          state_d = TC_SET_H;
        end
      end
      TC_SET_H: begin
        if (btn_start)     state_d = TC_IDLE;
        else if (btn_mode) state_d = TC_SET_M;
        else if (btn_inc) begin
          h1_d = h1_nx;
          h0_d = h0_nx;
        end
      end
      TC_SET_M: begin
        if (btn_start || btn_mode) state_d = TC_IDLE;
        else if (btn_inc) begin
          m1_d = m1_nx;
          m0_d = m0_nx;
        end
      end
      TC_RUN: begin
        if (btn_start) state_d = TC_PAUSE;
        else if (cnt_zero && !load_q && !guard_q) state_d = TC_ALARM;
      end
      TC_PAUSE: begin
        if (btn_start)     state_d = TC_RUN;
        else if (btn_mode) state_d = TC_IDLE;
      end
      TC_ALARM: begin
        if (any_btn) begin
          state_d     = TC_IDLE;
          alarm_cnt_d = '0;
        end else if (tick_1hz) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            state_d     = TC_IDLE;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TC_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    en_start_d[0] = (state_d == TC_RUN) && !load_d;
    en_start_d[1] = (state_d == TC_SET_H) || (state_d == TC_SET_M);
    field_sel_d   = (state_d == TC_SET_H) ? FIELD_HOUR :
                    (state_d == TC_SET_M) ? FIELD_MIN  : FIELD_NONE;
    alarm_d       = (state_d == TC_ALARM);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TC_IDLE;
      h1_q        <= BCD_ZERO;
      h0_q        <= BCD_ZERO;
      m1_q        <= BCD_ZERO;
      m0_q        <= BCD_ZERO;
      alarm_cnt_q <= '0;
      load_q      <= 1'b0;
      guard_q     <= 1'b0;
      en_start_q  <= 2'b00;
      field_sel_q <= FIELD_NONE;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      alarm_cnt_q <= alarm_cnt_d;
      load_q      <= load_d;
      guard_q     <= guard_d;
      en_start_q  <= en_start_d;
      field_sel_q <= field_sel_d;
      alarm_q     <= alarm_d;
    end
  end

  assign init_value_h1 = h1_q;
  assign init_value_h0 = h0_q;
  assign init_value_m1 = m1_q;
  assign init_value_m0 = m0_q;
  assign load          = load_q;
  assign en_start      = en_start_q;
  assign field_sel     = field_sel_q;
  assign alarm         = alarm_q;

endmodule
